change_dispenser: RTL and testbench

Downstream stage of the vending machine controller. Accepts a change amount in won when a transaction finishes and pays it out through the note/coin hopper as a sequence of single-cycle `change_1000` / `change_500` pulses, one per hopper acknowledgement. It prefers 1000-won units and falls back to 500-won units when the 1000 hopper is empty. Invalid requests, stock exhaustion and hopper timeouts are reported.

---
 rtl/change_dispenser.sv | 135 +++++++++++++
 tb/tb_change_dispenser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change payout sequencer: pays a won amount as 1000/500 hopper pulses, one per ack.
// Optional ack watchdog enabled by defining DISPENSE_TIMEOUT_EN.
module change_dispenser #(
    parameter int unsigned MAX_AMOUNT  = 5000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] amount,
    input  logic        empty_1000,
    input  logic        empty_500,
    input  logic        hop_ack,
    output logic        change_1000,
    output logic        change_500,
    output logic        busy,
    output logic        done,
    output logic        reject,
    output logic        fault,
    output logic [15:0] remaining
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT_ACK,
        DONE,
        FAULT
    } state_t;

    state_t      state;
    logic        unit_1000;
    logic [15:0] unit_val;
    logic        bad_request;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    logic [CNT_W-1:0] ack_cnt;
`endif

    always_comb begin
        unit_val    = unit_1000 ? 16'd1000 : 16'd500;
        bad_request = ({16'd0, remaining} > MAX_AMOUNT) || ((remaining % 16'd500) != 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            unit_1000   <= 1'b0;
            change_1000 <= 1'b0;
            change_500  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            reject      <= 1'b0;
            fault       <= 1'b0;
            remaining   <= '0;
`ifdef DISPENSE_TIMEOUT_EN
            ack_cnt     <= '0;
`endif
        end else begin
            change_1000 <= 1'b0;
            change_500  <= 1'b0;
            done        <= 1'b0;
            reject      <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        remaining <= amount;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (remaining == '0) begin
                        state <= DONE;
                    end else if (bad_request) begin
                        reject    <= 1'b1;
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Selection is redone every unit so a hopper emptying mid-payout is honoured.
                    if (remaining >= 16'd1000 && !empty_1000) begin
                        change_1000 <= 1'b1;
                        unit_1000   <= 1'b1;
                        state       <= WAIT_ACK;
                    end else if (remaining >= 16'd500 && !empty_500) begin
                        change_500 <= 1'b1;
                        unit_1000  <= 1'b0;
                        state      <= WAIT_ACK;
                    end else begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end
`ifdef DISPENSE_TIMEOUT_EN
                    ack_cnt <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (hop_ack) begin
                        remaining <= remaining - unit_val;
                        state     <= (remaining == unit_val) ? DONE : ISSUE;
`ifdef DISPENSE_TIMEOUT_EN
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    fault <= 1'b1;
                    busy  <= 1'b1;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;

    localparam int unsigned MAX = 5000;
`ifdef DISPENSE_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] amount = '0;
    logic        empty_1000 = 1'b0;
    logic        empty_500 = 1'b0;
    logic        hop_ack = 1'b0;
    logic        change_1000, change_500, busy, done, reject, fault;
    logic [15:0] remaining;

    int unsigned total = 0;
    int unsigned bad = 0;

    change_dispenser #(.MAX_AMOUNT(MAX), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .empty_1000(empty_1000), .empty_500(empty_500), .hop_ack(hop_ack),
        .change_1000(change_1000), .change_500(change_500), .busy(busy),
        .done(done), .reject(reject), .fault(fault), .remaining(remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst_pulses", {change_1000, change_500, done, reject}, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_rem", remaining, 0);
        reset = 1'b0;
    endtask

    // Model: validate, then pay greedily (1000 if owed and stocked, else 500, else fault).
    task automatic run_txn(input int unsigned amt, input int unsigned ack_dly,
                           input bit rand_flags, output bit faulted);
        int unsigned rem;
        int unsigned unit;
        faulted = 1'b0;
        start = 1'b1;
        amount = amt[15:0];
        tick();
        start = 1'b0;
        amount = 16'($urandom);
        check("accept_busy", busy, 1);
        check("accept_pulses", {change_1000, change_500, done, reject}, 0);
        tick();
        if (amt > MAX || amt % 500 != 0) begin
            check("reject", reject, 1);
            check("reject_busy", busy, 0);
            check("reject_rem", remaining, 0);
            check("reject_nopulse", {change_1000, change_500, done}, 0);
            tick();
            check("reject_once", reject, 0);
            return;
        end
        check("check_pulses", {change_1000, change_500, done, reject}, 0);
        rem = amt;
        while (rem != 0) begin
            if (rand_flags) begin
                empty_1000 = ($urandom_range(0, 3) == 0);
                empty_500  = ($urandom_range(0, 7) == 0);
            end
            tick();
            if (rem >= 1000 && !empty_1000) unit = 1000;
            else if (rem >= 500 && !empty_500) unit = 500;
            else unit = 0;
            if (unit == 0) begin
                check("fault_level", fault, 1);
                check("fault_busy", busy, 1);
                check("fault_nopulse", {change_1000, change_500, done}, 0);
                check("fault_rem", remaining, rem);
                faulted = 1'b1;
                return;
            end
            check("pulse_1000", change_1000, (unit == 1000));
            check("pulse_500", change_500, (unit == 500));
            check("pulse_rem", remaining, rem);
            for (int unsigned i = 0; i < ack_dly; i++) begin
                tick();
                check("wait_quiet", {change_1000, change_500, done, fault}, 0);
            end
            hop_ack = 1'b1;
            tick();
            hop_ack = 1'b0;
            rem -= unit;
            check("ack_rem", remaining, rem);
            check("ack_quiet", {change_1000, change_500, done, fault}, 0);
        end
        tick();
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_nopulse", {change_1000, change_500, reject, fault}, 0);
        tick();
        check("done_once", done, 0);
    endtask

    initial begin
        bit f;
        int unsigned amt;
        tick();
        do_reset();

        run_txn(3500, 2, 1'b0, f);
        check("t3500_nofault", fault, 0);
        empty_1000 = 1'b1;
        run_txn(2000, 1, 1'b0, f);
        empty_1000 = 1'b0;
        run_txn(1250, 0, 1'b0, f);
        run_txn(5500, 0, 1'b0, f);
        run_txn(0, 0, 1'b0, f);
        run_txn(5000, 0, 1'b0, f);

        empty_500 = 1'b1;
        run_txn(1500, 1, 1'b0, f);
        check("t1500_faulted", f, 1);
        start = 1'b1;
        amount = 16'd1000;
        tick();
        start = 1'b0;
        tick();
        check("fault_start_ign", {change_1000, change_500, done, reject}, 0);
        check("fault_hold_rem", remaining, 500);
        check("fault_hold", {busy, fault}, 2'b11);
        empty_500 = 1'b0;
        do_reset();

        // Reset while waiting for an ack; a late ack must not revive the payout.
        start = 1'b1;
        amount = 16'd3000;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rw_pulse", change_1000, 1);
        tick();
        do_reset();
        hop_ack = 1'b1;
        tick();
        hop_ack = 1'b0;
        check("rw_ack_ign", {change_1000, change_500, done, busy}, 0);
        check("rw_rem", remaining, 0);
        tick();
        check("rw_idle", {change_1000, change_500, done, busy}, 0);

`ifdef DISPENSE_TIMEOUT_EN
        start = 1'b1;
        amount = 16'd1000;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("to_pulse", change_1000, 1);
        for (int unsigned i = 1; i < TO; i++) begin
            tick();
            check("to_early", fault, 0);
        end
        tick();
        check("to_fault", fault, 1);
        check("to_rem", remaining, 1000);
        do_reset();
        run_txn(1000, TO - 1, 1'b0, f);
        check("to_ack_wins", f, 0);
`else
        run_txn(1000, 20, 1'b0, f);
        check("no_timeout", f, 0);
`endif

        for (int unsigned n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: amt = $urandom_range(0, 65535);
                1: amt = $urandom_range(0, 13) * 500;
                default: amt = $urandom_range(1, 10) * 500;
            endcase
            run_txn(amt, $urandom_range(0, 4), 1'b1, f);
            if (f) do_reset();
        end
        empty_1000 = 1'b0;
        empty_500  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
